serial_in: RTL and testbench

- UART receiver (8N1, LSB first), the receive-side counterpart of the serial transmitter.
- Converts the board RX pin into bytes held in a small show-ahead FIFO.
- The Brainfuck core's ',' (input) instruction pops bytes from this FIFO via a valid/ready handshake.
- Runs on the fast base clock (clk), not the divided core clock.

---
 rtl/serial_in_if.sv | 10 +
 rtl/serial_in.sv | 176 +++++++++++++++++
 tb/tb_serial_in.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_in_if.sv
// Byte handshake between the UART receiver FIFO head and its consumer.
// master = receiver (drives char/valid), slave = consumer (drives ready).
interface serial_in_if;
    logic [7:0] char;
    logic       valid;
    logic       ready;

    modport master (output char, output valid, input ready);
    modport slave  (input char, input valid, output ready);
endinterface

// File: rtl/serial_in.sv
// UART receiver (8N1, LSB first) feeding a show-ahead FIFO popped by valid/ready.
// Define SERIAL_IN_PARITY_EN to receive 8E1 frames and report parity_err.
module serial_in #(
    parameter int clks_per_bit     = 434,
    parameter int fifo_depth_width = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    serial_in_if.master       rx_bus,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);
    localparam int cnt_w = $clog2(clks_per_bit);
    localparam logic [cnt_w-1:0] bit_last  = cnt_w'(clks_per_bit - 1);
    localparam logic [cnt_w-1:0] half_last = cnt_w'(clks_per_bit / 2 - 1);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_start  = 3'd1;
    localparam logic [2:0] st_data   = 3'd2;
    localparam logic [2:0] st_stop   = 3'd4;
    localparam logic [2:0] st_wait   = 3'd5;
`ifdef SERIAL_IN_PARITY_EN
    localparam logic [2:0] st_parity = 3'd3;
`endif

    logic              rx_meta, rx_s, rx_prev;
    logic [2:0]        state;
    logic [cnt_w-1:0]  cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              tick, stop_tick, push, pop, wr_ok, par_bad;

    logic [7:0]                  mem [0:(1 << fifo_depth_width) - 1];
    logic [fifo_depth_width:0]   wr_ptr, rd_ptr;
    logic                        empty, full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        tick      = (cnt == bit_last);
        stop_tick = (state == st_stop) && tick;
        push      = stop_tick && rx_s && !par_bad;
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[fifo_depth_width] != rd_ptr[fifo_depth_width]) &&
                    (wr_ptr[fifo_depth_width-1:0] == rd_ptr[fifo_depth_width-1:0]);
        pop       = !empty && rx_bus.ready;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        wr_ok     = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= st_idle;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (rx_prev && !rx_s) begin
                        state <= st_start;
                        cnt   <= '0;
                    end
                end
                st_start: begin
                    if (cnt == half_last) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? st_idle : st_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                st_data: begin
                    if (tick) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef SERIAL_IN_PARITY_EN
                            state <= st_parity;
`else
                            state <= st_stop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SERIAL_IN_PARITY_EN
                st_parity: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= st_stop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                st_stop: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= rx_s ? st_idle : st_wait;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                st_wait: begin
                    // A held-low break stays here so it reports only one frame error.
                    if (rx_s) state <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == st_data && tick) shift_reg <= {rx_s, shift_reg[7:1]};
    end

`ifdef SERIAL_IN_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (state == st_parity && tick) par_bit <= rx_s;
    end

    assign par_bad = ^{shift_reg, par_bit};

    // Parity is reported only when the stop bit is good; frame errors win.
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= stop_tick && rx_s && par_bad;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_tick && !rx_s;
            overrun   <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[fifo_depth_width-1:0]] <= shift_reg;
    end

    assign rx_bus.valid = !empty;
    assign rx_bus.char  = empty ? 8'h00 : mem[rd_ptr[fifo_depth_width-1:0]];
endmodule

// File: tb/tb_serial_in.sv
// Directed bench for serial_in at 8 clocks per bit and a 4-entry FIFO.
module tb_serial_in;
    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic frame_err, overrun, parity_err;
    int   total = 0;
    int   bad   = 0;
    int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int   fe0, ov0;
    logic pre_valid;
`ifdef SERIAL_IN_PARITY_EN
    logic par_flip = 1'b0;
`endif

    serial_in_if bus ();

    serial_in #(.clks_per_bit(8), .fifo_depth_width(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_bus     (bus),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
        if (parity_err) pe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends a frame and returns 1 time unit after the stop-bit sample edge.
    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input logic pop_at_sample, output logic pv);
        @(posedge clk); #1 uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(posedge clk);
            #1 uart_rx = d[i];
        end
`ifdef SERIAL_IN_PARITY_EN
        repeat (8) @(posedge clk);
        #1 uart_rx = (^d) ^ par_flip;
`endif
        repeat (8) @(posedge clk);
        #1 uart_rx = stopb;
        repeat (6) @(posedge clk);
        #1 pv = bus.valid;
        bus.ready = pop_at_sample;
        @(posedge clk);
        #1 bus.ready = 1'b0;
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        check(tag, bus.char, exp);
        bus.ready = 1'b1;
        @(posedge clk);
        #1 bus.ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.valid, 0);
        check("rst_char", bus.char, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        send_frame(8'h41, 1'b1, 1'b0, pre_valid);
        check("b41_pre_valid", pre_valid, 0);
        check("b41_valid", bus.valid, 1);
        check("b41_char", bus.char, 8'h41);
        check("b41_frame_err", frame_err, 0);
        check("b41_overrun", overrun, 0);
        pop_byte("b41_pop", 8'h41);
        check("b41_empty", bus.valid, 0);

        ov0 = ov_cnt;
        send_frame(8'h00, 1'b1, 1'b0, pre_valid);
        send_frame(8'hFF, 1'b1, 1'b0, pre_valid);
        send_frame(8'h5A, 1'b1, 1'b0, pre_valid);
        send_frame(8'hA5, 1'b1, 1'b0, pre_valid);
        check("fill_char", bus.char, 8'h00);
        send_frame(8'h3C, 1'b1, 1'b0, pre_valid);
        check("ovr_pulse", overrun, 1);
        check("ovr_head", bus.char, 8'h00);
        @(posedge clk); #1;
        check("ovr_one_cycle", overrun, 0);
        check("ovr_count", ov_cnt - ov0, 1);
        pop_byte("ovr_pop0", 8'h00);
        pop_byte("ovr_pop1", 8'hFF);
        pop_byte("ovr_pop2", 8'h5A);
        pop_byte("ovr_pop3", 8'hA5);
        check("ovr_empty", bus.valid, 0);

        ov0 = ov_cnt;
        send_frame(8'h00, 1'b1, 1'b0, pre_valid);
        send_frame(8'hFF, 1'b1, 1'b0, pre_valid);
        send_frame(8'h5A, 1'b1, 1'b0, pre_valid);
        send_frame(8'hA5, 1'b1, 1'b0, pre_valid);
        send_frame(8'h77, 1'b1, 1'b1, pre_valid);
        check("simul_no_ovr", overrun, 0);
        check("simul_head", bus.char, 8'hFF);
        pop_byte("simul_pop0", 8'hFF);
        pop_byte("simul_pop1", 8'h5A);
        pop_byte("simul_pop2", 8'hA5);
        pop_byte("simul_pop3", 8'h77);
        check("simul_empty", bus.valid, 0);
        check("simul_ovr_count", ov_cnt - ov0, 0);

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_valid", bus.valid, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_ovr", ov_cnt - ov0, 0);

        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0, pre_valid);
        check("brk_frame_err", frame_err, 1);
        check("brk_valid", bus.valid, 0);
        repeat (40) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("brk_fe_once", fe_cnt - fe0, 1);
        check("brk_not_pushed", bus.valid, 0);
        send_frame(8'h12, 1'b1, 1'b0, pre_valid);
        check("brk_after_valid", bus.valid, 1);
        check("brk_after_char", bus.char, 8'h12);
        check("brk_after_fe", frame_err, 0);

        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (8) @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        uart_rx = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", bus.valid, 0);
        check("mid_rst_char", bus.char, 8'h00);
        check("mid_rst_fe", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        send_frame(8'h24, 1'b1, 1'b0, pre_valid);
        check("post_rst_pre_valid", pre_valid, 0);
        check("post_rst_valid", bus.valid, 1);
        check("post_rst_char", bus.char, 8'h24);
        pop_byte("post_rst_pop", 8'h24);
        check("post_rst_empty", bus.valid, 0);

`ifdef SERIAL_IN_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, pre_valid);
        check("par_bad_pulse", parity_err, 1);
        check("par_bad_valid", bus.valid, 0);
        check("par_bad_fe", frame_err, 0);
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1, 1'b0, pre_valid);
        check("par_ok_pulse", parity_err, 0);
        check("par_ok_valid", bus.valid, 1);
        check("par_ok_char", bus.char, 8'h03);
        pop_byte("par_ok_pop", 8'h03);
        par_flip = 1'b1;
        send_frame(8'h03, 1'b0, 1'b0, pre_valid);
        check("par_both_fe", frame_err, 1);
        check("par_both_pe", parity_err, 0);
        par_flip = 1'b0;
        #1 uart_rx = 1'b1;
        repeat (10) @(posedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
